// File: rtl/disp_imm_packer_if.sv
// disp_imm_packer_if
//   Handshake bundle between a field-set producer and the packer, and
//   between the packer and the downstream consumer of packed words.
//   master : the side that drives field sets and consumes packed words (bench / upstream)
//   slave  : the packer itself
// Signals:
//   in_valid / in_ready          field-set handshake
//   in_disp, in_disp_bytes       displacement value and its length (0, 1, 4)
//   in_imm, in_imm_bytes         immediate value and its length (0, 1, 2, 4, 6)
//   out_valid / out_ready        packed-word handshake
//   out_displace_n_imm           packed stream, stream byte k at [63-8k:56-8k]
//   out_displacement_bytes       displacement length of the head word
//   out_immediete_bytes          immediate length of the head word
interface disp_imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_disp;
  logic [3:0]  in_disp_bytes;
  logic [47:0] in_imm;
  logic [3:0]  in_imm_bytes;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_displace_n_imm;
  logic [3:0]  out_displacement_bytes;
  logic [3:0]  out_immediete_bytes;

  modport master (
    output in_valid, in_disp, in_disp_bytes, in_imm, in_imm_bytes, out_ready,
    input  in_ready, out_valid, out_displace_n_imm, out_displacement_bytes,
           out_immediete_bytes
  );

  modport slave (
    input  in_valid, in_disp, in_disp_bytes, in_imm, in_imm_bytes, out_ready,
    output in_ready, out_valid, out_displace_n_imm, out_displacement_bytes,
           out_immediete_bytes
  );
endinterface

// File: rtl/disp_imm_packer.sv
// disp_imm_packer
//   Packs a displacement and an immediate into one 64-bit byte stream
//   (displacement bytes first, each field LSB byte first, zero filled) and
//   buffers the result in a 2-entry FIFO. Field sets with an illegal length
//   combination complete their handshake but are dropped; each one raises a
//   one-cycle err_pulse and bumps a saturating err_count.
// Ports:
//   clk        single rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        disp_imm_packer_if.slave (field-set input, packed-word output)
//   err_pulse  high for the cycle after an illegal field set is accepted
//   err_count  saturating count of illegal field sets
module disp_imm_packer (
  input  logic                  clk,
  input  logic                  reset,
  disp_imm_packer_if.slave      bus,
  output logic                  err_pulse,
  output logic [7:0]            err_count
);

  typedef struct packed {
    logic [63:0] word;
    logic [3:0]  disp_bytes;
    logic [3:0]  imm_bytes;
  } entry_t;

  localparam entry_t ENTRY_ZERO = 72'd0;

  // Length check; the sum is taken 5 bits wide so 15+15 cannot wrap below 9.
  function automatic logic is_legal(input logic [3:0] d, input logic [3:0] i);
    logic       d_ok;
    logic       i_ok;
    logic [4:0] sum;
    case (d)
      4'd0, 4'd1, 4'd4: d_ok = 1'b1;
      default:          d_ok = 1'b0;
    endcase
    case (i)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6: i_ok = 1'b1;
      default:                      i_ok = 1'b0;
    endcase
    sum = {1'b0, d} + {1'b0, i};
    return d_ok && i_ok && (sum <= 5'd8);
  endfunction

  // Build the stream little-endian (byte k at bits [8k+7:8k]) by masking each
  // field to its length and shifting the immediate past the displacement,
  // then byte-reverse so stream byte 0 lands in the top byte.
  function automatic logic [63:0] pack(input logic [31:0] disp, input logic [3:0] d,
                                       input logic [47:0] imm, input logic [3:0] i);
    logic [31:0] disp_m;
    logic [47:0] imm_m;
    logic [63:0] le;
    logic [63:0] be;
    case (d)
      4'd1:    disp_m = {24'h000000, disp[7:0]};
      4'd4:    disp_m = disp;
      default: disp_m = 32'h00000000;
    endcase
    case (i)
      4'd1:    imm_m = {40'h0000000000, imm[7:0]};
      4'd2:    imm_m = {32'h00000000, imm[15:0]};
      4'd4:    imm_m = {16'h0000, imm[31:0]};
      4'd6:    imm_m = imm;
      default: imm_m = 48'h000000000000;
    endcase
    le = {32'h00000000, disp_m} | ({16'h0000, imm_m} << {d, 3'b000});
    be = 64'h0000000000000000;
    for (int k = 0; k < 8; k++) begin
      be[63 - 8*k -: 8] = le[8*k +: 8];
    end
    return be;
  endfunction

  // State: FIFO occupancy, head/second entries, registered flags and error state.
  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;

  logic   accept_s;
  logic   legal_s;
  logic   push_s;
  logic   pop_s;
  entry_t new_s;

  // Handshake decode and packing of the incoming field set.
  always_comb begin
    accept_s = bus.in_valid && in_ready_q;
    legal_s  = is_legal(bus.in_disp_bytes, bus.in_imm_bytes);
    push_s   = accept_s && legal_s;
    pop_s    = out_valid_q && bus.out_ready;
    new_s    = {pack(bus.in_disp, bus.in_disp_bytes, bus.in_imm, bus.in_imm_bytes),
                bus.in_disp_bytes, bus.in_imm_bytes};
  end

  // Next-state for occupancy, FIFO storage (head is always the output entry) and errors.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
      end else if (push_s) begin
        // Pop and push at count 1: the new entry becomes head straight away.
        head_d = new_s;
      end else begin
        head_d = ENTRY_ZERO;
      end
    end else if (push_s) begin
      if (count_q == 2'd0) begin
        head_d = new_s;
      end else begin
        tail_d = new_s;
      end
    end else begin
      head_d = head_q;
    end

    in_ready_d  = (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
    err_pulse_d = accept_s && !legal_s;
    if (err_pulse_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State registers; reset clears buffered entries and any pending error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= 2'd0;
      head_q      <= ENTRY_ZERO;
      tail_q      <= ENTRY_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready               = in_ready_q;
  assign bus.out_valid              = out_valid_q;
  assign bus.out_displace_n_imm     = head_q.word;
  assign bus.out_displacement_bytes = head_q.disp_bytes;
  assign bus.out_immediete_bytes    = head_q.imm_bytes;
  assign err_pulse                  = err_pulse_q;
  assign err_count                  = err_count_q;

endmodule
